// File: rtl/loop_nest_ctrl.sv
// Three-level nested-loop sequencer (m outer, n middle, k inner) with inclusive bounds,
// streaming one (m,n,k) tuple per valid/ready handshake and flagging the first/last k step.
module loop_nest_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] bound_m_i,
    input  logic [WIDTH-1:0] bound_n_i,
    input  logic [WIDTH-1:0] bound_k_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] idx_m_o,
    output logic [WIDTH-1:0] idx_n_o,
    output logic [WIDTH-1:0] idx_k_o,
    output logic             first_k_o,
    output logic             last_k_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] bnd_m_r, bnd_n_r, bnd_k_r;
    logic [WIDTH-1:0] bnd_m_s, bnd_n_s, bnd_k_s;
    logic [WIDTH-1:0] idx_m_r, idx_n_r, idx_k_r;
    logic [WIDTH-1:0] idx_m_s, idx_n_s, idx_k_s;
    logic             valid_r, first_k_r, last_k_r, busy_r, done_r;
    logic             valid_s, first_k_s, last_k_s, busy_s, done_s;
    logic             at_m_s, at_n_s, at_k_s;

    // Wrap detection compares against the latched bounds, so the +1 never overflows.
    assign at_m_s = (idx_m_r == bnd_m_r);
    assign at_n_s = (idx_n_r == bnd_n_r);
    assign at_k_s = (idx_k_r == bnd_k_r);

    // Next-state, bound latch and index advance.
    always_comb begin
        state_s = state_r;
        bnd_m_s = bnd_m_r;
        bnd_n_s = bnd_n_r;
        bnd_k_s = bnd_k_r;
        idx_m_s = idx_m_r;
        idx_n_s = idx_n_r;
        idx_k_s = idx_k_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_i) begin
                    idx_m_s = ZERO_C;
                    idx_n_s = ZERO_C;
                    idx_k_s = ZERO_C;
                end else if (start_i) begin
                    state_s = ST_RUN;
                    bnd_m_s = bound_m_i;
                    bnd_n_s = bound_n_i;
                    bnd_k_s = bound_k_i;
                    idx_m_s = ZERO_C;
                    idx_n_s = ZERO_C;
                    idx_k_s = ZERO_C;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (clear_i) begin
                    state_s = ST_IDLE;
                    idx_m_s = ZERO_C;
                    idx_n_s = ZERO_C;
                    idx_k_s = ZERO_C;
                end else if (ready_i) begin
                    if (at_k_s && at_n_s && at_m_s) begin
                        state_s = ST_DONE;
                        idx_m_s = ZERO_C;
                        idx_n_s = ZERO_C;
                        idx_k_s = ZERO_C;
                    end else if (at_k_s) begin
                        idx_k_s = ZERO_C;
                        if (at_n_s) begin
                            idx_n_s = ZERO_C;
                            idx_m_s = idx_m_r + ONE_C;
                        end else begin
                            idx_n_s = idx_n_r + ONE_C;
                        end
                    end else begin
                        idx_k_s = idx_k_r + ONE_C;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                idx_m_s = ZERO_C;
                idx_n_s = ZERO_C;
                idx_k_s = ZERO_C;
            end
        endcase
    end

    // Output flags are derived from the next state so they register alongside the indices.
    always_comb begin
        valid_s   = (state_s == ST_RUN);
        first_k_s = valid_s && (idx_k_s == ZERO_C);
        last_k_s  = valid_s && (idx_k_s == bnd_k_s);
        busy_s    = (state_s != ST_IDLE);
        done_s    = (state_s == ST_DONE);
    end

    // State, bounds, indices and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            bnd_m_r   <= ZERO_C;
            bnd_n_r   <= ZERO_C;
            bnd_k_r   <= ZERO_C;
            idx_m_r   <= ZERO_C;
            idx_n_r   <= ZERO_C;
            idx_k_r   <= ZERO_C;
            valid_r   <= 1'b0;
            first_k_r <= 1'b0;
            last_k_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            bnd_m_r   <= bnd_m_s;
            bnd_n_r   <= bnd_n_s;
            bnd_k_r   <= bnd_k_s;
            idx_m_r   <= idx_m_s;
            idx_n_r   <= idx_n_s;
            idx_k_r   <= idx_k_s;
            valid_r   <= valid_s;
            first_k_r <= first_k_s;
            last_k_r  <= last_k_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign valid_o   = valid_r;
    assign idx_m_o   = idx_m_r;
    assign idx_n_o   = idx_n_r;
    assign idx_k_o   = idx_k_r;
    assign first_k_o = first_k_r;
    assign last_k_o  = last_k_r;
    assign busy_o    = busy_r;
    assign done_o    = done_r;

endmodule
